// File: rtl/energy_classifier_pkg.sv
// Shared types for the energy classifier: FSM state enum and accumulator width.
// Optional macro CLASSIFIER_ENERGY_OUT_EN exposes the final energy word.
package classifier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int acc_w(input int bw, input int n);
    return bw + $clog2(n);
  endfunction

endpackage

// File: rtl/energy_classifier_if.sv
// Frame-in / result-out handshake bundle for the energy classifier.
// With CLASSIFIER_ENERGY_OUT_EN defined, the bundle also carries send_energy.
interface energy_classifier_if
  import classifier_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) ();

  localparam int ACC_W = acc_w(BIT_WIDTH, N_SAMPLES);

  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_mask;
  logic [BIT_WIDTH-1:0]                cutoff_mag;
  logic                                recv_val;
  logic                                recv_rdy;
  logic                                send_msg;
  logic                                send_val;
  logic                                send_rdy;
`ifdef CLASSIFIER_ENERGY_OUT_EN
  logic [ACC_W-1:0]                    send_energy;
`endif

  modport master (
    output recv_msg,
    output recv_mask,
    output cutoff_mag,
    output recv_val,
    input  recv_rdy,
    input  send_msg,
    input  send_val,
`ifdef CLASSIFIER_ENERGY_OUT_EN
    input  send_energy,
`endif
    output send_rdy
  );

  modport slave (
    input  recv_msg,
    input  recv_mask,
    input  cutoff_mag,
    input  recv_val,
    output recv_rdy,
    output send_msg,
    output send_val,
`ifdef CLASSIFIER_ENERGY_OUT_EN
    output send_energy,
`endif
    input  send_rdy
  );

endinterface

// File: rtl/energy_classifier.sv
// Sums enabled FFT bin magnitudes one bin per cycle and flags energy > cutoff.
// Optional macro CLASSIFIER_ENERGY_OUT_EN drives the final sum on send_energy.
module energy_classifier
  import classifier_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8
) (
  input  logic               clk,
  input  logic               reset,
  energy_classifier_if.slave bus
);

  localparam int ACC_W = acc_w(BIT_WIDTH, N_SAMPLES);
  localparam int IDX_W = $clog2(N_SAMPLES) + 1;

  state_t r_state;
  state_t w_next;

  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] r_msg;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] r_mask;
  logic [BIT_WIDTH-1:0]                r_cut;
  logic [ACC_W-1:0]                    r_acc;
  logic [IDX_W-1:0]                    r_idx;
  logic                                r_res;

  logic             w_last;
  logic             w_en;
  logic [ACC_W-1:0] w_add;

  // Index runs one past the last bin; that extra cycle registers the compare.
  assign w_last = (r_idx == IDX_W'(N_SAMPLES));
  assign w_en   = |r_mask[r_idx[IDX_W-2:0]];
  assign w_add  = w_en ? ACC_W'(r_msg[r_idx[IDX_W-2:0]]) : '0;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.recv_rdy = 1'b0;
    bus.send_val = 1'b0;
    bus.send_msg = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.recv_rdy = 1'b1;
        if (bus.recv_val) w_next = ACCUM;
      end
      ACCUM: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        bus.send_val = 1'b1;
        bus.send_msg = r_res;
        if (bus.send_rdy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_msg  <= '0;
      r_mask <= '0;
      r_cut  <= '0;
      r_acc  <= '0;
      r_idx  <= '0;
      r_res  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.recv_val) begin
            r_msg  <= bus.recv_msg;
            r_mask <= bus.recv_mask;
            r_cut  <= bus.cutoff_mag;
            r_acc  <= '0;
            r_idx  <= '0;
            r_res  <= 1'b0;
          end
        end
        ACCUM: begin
          if (w_last) begin
            r_res <= (r_acc > ACC_W'(r_cut));
          end else begin
            r_acc <= r_acc + w_add;
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CLASSIFIER_ENERGY_OUT_EN
  assign bus.send_energy = (r_state == DONE) ? r_acc : '0;
`endif

endmodule

// File: tb/tb_energy_classifier.sv
// Directed bench for energy_classifier (N_SAMPLES=8, BIT_WIDTH=32).
// Set CLASSIFIER_ENERGY_OUT_EN to also check send_energy.
module tb_energy_classifier;

  localparam int BW = 32;
  localparam int NS = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  energy_classifier_if #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) bus ();

  energy_classifier #(
    .BIT_WIDTH (BW),
    .DECIMAL_PT(16),
    .N_SAMPLES (NS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] base, input logic [31:0] step,
                      input logic [7:0] en, input logic [31:0] mw,
                      input logic [31:0] cut);
    for (int i = 0; i < NS; i++) begin
      bus.recv_msg[i]  = base + step * i;
      bus.recv_mask[i] = en[i] ? mw : 32'h0;
    end
    bus.cutoff_mag = cut;
  endtask

  // Accept a frame, then scramble inputs to prove they were captured.
  task automatic accept(input string tag);
    chk({tag, "_rdy"}, 64'(bus.recv_rdy), 64'h1);
    bus.recv_val = 1'b1;
    tick();
    bus.recv_val = 1'b0;
    for (int i = 0; i < NS; i++) begin
      bus.recv_msg[i]  = 32'h0;
      bus.recv_mask[i] = 32'hFFFF_FFFF;
    end
    bus.cutoff_mag = ~bus.cutoff_mag;
  endtask

  task automatic wait_res(input string tag, input logic exp_msg);
    int lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.send_val) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd9);
    chk({tag, "_msg"}, 64'(bus.send_msg), 64'(exp_msg));
  endtask

  task automatic hshake(input string tag);
    bus.send_rdy = 1'b1;
    tick();
    bus.send_rdy = 1'b0;
    chk({tag, "_idle"}, 64'(bus.recv_rdy), 64'h1);
    chk({tag, "_sv0"}, 64'(bus.send_val), 64'h0);
  endtask

  initial begin
    int seen;
    reset          = 1'b0;
    bus.recv_val   = 1'b0;
    bus.send_rdy   = 1'b0;
    load(32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    chk("rst_rdy", 64'(bus.recv_rdy), 64'h1);
    chk("rst_sv", 64'(bus.send_val), 64'h0);
    chk("rst_msg", 64'(bus.send_msg), 64'h0);
`ifdef CLASSIFIER_ENERGY_OUT_EN
    chk("rst_nrg", 64'(bus.send_energy), 64'h0);
`endif

    // 4 bins of 0x1_0000 = 0x4_0000 > 0x3_0000
    load(32'h0001_0000, 32'h0, 8'hF0, 32'h1, 32'h0003_0000);
    accept("cross");
    wait_res("cross", 1'b1);
`ifdef CLASSIFIER_ENERGY_OUT_EN
    chk("cross_nrg", 64'(bus.send_energy), 64'h4_0000);
`endif
    hshake("cross");

    // equal is not greater
    load(32'h0001_0000, 32'h0, 8'hF0, 32'h1, 32'h0004_0000);
    accept("eq");
    wait_res("eq", 1'b0);
    hshake("eq");

    // even bins of 1..8: 1+3+5+7 = 16 > 15, mask word with only MSB set
    load(32'h1, 32'h1, 8'h55, 32'h8000_0000, 32'd15);
    accept("even");
    wait_res("even", 1'b1);
`ifdef CLASSIFIER_ENERGY_OUT_EN
    chk("even_nrg", 64'(bus.send_energy), 64'd16);
`endif
    hshake("even");

    // width boundary plus backpressure and ignored recv_val
    load(32'hFFFF_FFFF, 32'h0, 8'hFF, 32'h1, 32'hFFFF_FFFF);
    accept("wide");
    wait_res("wide", 1'b1);
`ifdef CLASSIFIER_ENERGY_OUT_EN
    chk("wide_nrg", 64'(bus.send_energy), 64'h7_FFFF_FFF8);
`endif
    load(32'h0, 32'h0, 8'h00, 32'h0, 32'hFFFF_FFFF);
    bus.recv_val = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_sv", 64'(bus.send_val), 64'h1);
      chk("bp_msg", 64'(bus.send_msg), 64'h1);
      chk("bp_rdy", 64'(bus.recv_rdy), 64'h0);
    end
    bus.recv_val = 1'b0;
    hshake("wide");
    tick();
    chk("bp_nofrm", 64'(bus.recv_rdy), 64'h1);

    // reset during the third ACCUM cycle
    load(32'h0001_0000, 32'h0, 8'hF0, 32'h1, 32'h0003_0000);
    accept("mid");
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rdy", 64'(bus.recv_rdy), 64'h1);
    chk("mid_sv", 64'(bus.send_val), 64'h0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.send_val) seen++;
    end
    chk("mid_nores", 64'(seen), 64'h0);

    // all bins disabled, cutoff 0: 0 > 0 is false
    load(32'h0001_0000, 32'h0, 8'h00, 32'h1, 32'h0);
    accept("zero");
    wait_res("zero", 1'b0);
`ifdef CLASSIFIER_ENERGY_OUT_EN
    chk("zero_nrg", 64'(bus.send_energy), 64'h0);
`endif
    hshake("zero");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
